// File: rtl/sd_pkg.sv
// Shared definitions for the SD DAT0 block receiver.
// Holds the receiver state encoding, CRC-16 polynomial and block-size limit.
// Also provides the block-length normalisation helper used on start.
package sd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_START,
        DATA,
        CRC,
        END_BIT
    } sd_state_t;

    localparam logic [15:0] CRC_POLY    = 16'h1021;
    localparam int          MAX_BLK_LEN = 512;

    // Index of the last byte of a block: 0 means a full block, oversize is clamped.
    function automatic logic [9:0] last_byte_idx(input logic [9:0] len);
        if (len == 10'd0 || len > 10'(MAX_BLK_LEN)) begin
            return 10'(MAX_BLK_LEN - 1);
        end
        return len - 10'd1;
    endfunction

endpackage

// File: rtl/sd_crc16_core.sv
// Serial CRC-16 (x^16+x^12+x^5+1), one bit per enabled cycle, MSB-first, init 0.
// Latency: crc reflects a bit on the cycle after en.
// Backpressure: none; clr has priority over en.
module sd_crc16_core
    import sd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        clr,
    input  logic        en,
    input  logic        d,
    output logic [15:0] crc
);

    logic fb;

    assign fb = crc[15] ^ d;

    // Galois-form LFSR update on each enabled bit.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            crc <= 16'h0000;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/sd_data_rx.sv
// SD DAT0 single-line block receiver: start bit, MSB-first bytes, CRC-16, end bit.
// Latency: byte_valid/done appear one cycle after the strobe that completes them.
// Backpressure: none; all progress is paced by bit_en. Optional start-bit timeout
// is built only when SD_DATA_RX_TIMEOUT_EN is defined.
module sd_data_rx
    import sd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_en,
    input  logic       dat_in,
    input  logic       start,
    input  logic [9:0] blk_len,
    output logic       busy,
    output logic [7:0] byte_out,
    output logic       byte_valid,
    output logic       done,
    output logic       crc_ok,
    output logic       end_err,
    output logic       timeout
);

    sd_state_t   state;
    sd_state_t   state_nx;
    logic [2:0]  bit_cnt;
    logic [9:0]  byte_cnt;
    logic [9:0]  last_idx;
    logic [3:0]  crc_cnt;
    logic [6:0]  shreg;
    logic [15:0] rx_crc;
    logic [15:0] calc_crc;

    logic start_acc;
    logic start_bit;
    logic data_bit;
    logic byte_end;
    logic blk_end;
    logic crc_bit;
    logic crc_end;
    logic end_take;
    logic to_hit;

    assign start_acc = (state == IDLE) && start;
    assign start_bit = (state == WAIT_START) && bit_en && !dat_in;
    assign data_bit  = (state == DATA) && bit_en;
    assign byte_end  = data_bit && (bit_cnt == 3'd7);
    assign blk_end   = byte_end && (byte_cnt == last_idx);
    assign crc_bit   = (state == CRC) && bit_en;
    assign crc_end   = crc_bit && (crc_cnt == 4'd15);
    assign end_take  = (state == END_BIT) && bit_en;
    assign busy      = (state != IDLE);

`ifdef SD_DATA_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TW-1:0] to_cnt;

    // A line-high strobe that would be the TIMEOUT_CYCLES-th in WAIT_START aborts the wait.
    assign to_hit = (state == WAIT_START) && bit_en && dat_in &&
                    (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    // Count strobes spent waiting for the start bit; restart outside WAIT_START.
    always_ff @(posedge clk) begin
        if (rst || state != WAIT_START) begin
            to_cnt <= '0;
        end else if (bit_en) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // One-cycle timeout pulse following the aborting strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= to_hit;
        end
    end
`else
    // The limit only matters when the timeout feature is built.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TIMEOUT_CYCLES;
    assign to_hit  = 1'b0;
    assign timeout = 1'b0;
`endif

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state logic; every transition except arming is gated by bit_en.
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:       if (start) state_nx = WAIT_START;
            WAIT_START: begin
                if (start_bit) begin
                    state_nx = DATA;
                end else if (to_hit) begin
                    state_nx = IDLE;
                end
            end
            DATA:       if (blk_end) state_nx = CRC;
            CRC:        if (crc_end) state_nx = END_BIT;
            END_BIT:    if (bit_en) state_nx = IDLE;
            default:    state_nx = IDLE;
        endcase
    end

    // Block length capture, bit/byte/CRC counters and deserialisers.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_idx <= 10'd0;
            bit_cnt  <= 3'd0;
            byte_cnt <= 10'd0;
            crc_cnt  <= 4'd0;
            shreg    <= 7'd0;
            rx_crc   <= 16'h0000;
        end else begin
            if (start_acc) begin
                last_idx <= last_byte_idx(blk_len);
            end
            if (start_bit) begin
                bit_cnt  <= 3'd0;
                byte_cnt <= 10'd0;
                crc_cnt  <= 4'd0;
            end
            if (data_bit) begin
                shreg   <= {shreg[5:0], dat_in};
                bit_cnt <= bit_cnt + 3'd1;
                if (byte_end) begin
                    byte_cnt <= byte_cnt + 10'd1;
                end
            end
            if (crc_bit) begin
                rx_crc  <= {rx_crc[14:0], dat_in};
                crc_cnt <= crc_cnt + 4'd1;
            end
        end
    end

    // Result outputs: byte/done pulses, status held until the next accepted start.
    always_ff @(posedge clk) begin
        if (rst) begin
            byte_out   <= 8'h00;
            byte_valid <= 1'b0;
            done       <= 1'b0;
            crc_ok     <= 1'b0;
            end_err    <= 1'b0;
        end else begin
            byte_valid <= byte_end;
            done       <= end_take;
            if (byte_end) begin
                byte_out <= {shreg, dat_in};
            end
            if (start_acc) begin
                crc_ok  <= 1'b0;
                end_err <= 1'b0;
            end
            if (end_take) begin
                crc_ok  <= (calc_crc == rx_crc);
                end_err <= !dat_in;
            end
        end
    end

    sd_crc16_core u_crc (
        .clk (clk),
        .rst (rst),
        .clr (start_bit),
        .en  (data_bit),
        .d   (dat_in),
        .crc (calc_crc)
    );

endmodule

// File: tb/tb_sd_data_rx.sv
// Directed bench for sd_data_rx: table of short blocks plus long-block,
// timeout, reset and start-during-data sequences.
// Build with or without SD_DATA_RX_TIMEOUT_EN; expectations follow the macro.
module tb_sd_data_rx;

    logic       clk = 1'b0;
    logic       rst;
    logic       bit_en;
    logic       dat_in;
    logic       start;
    logic [9:0] blk_len;
    logic       busy;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       done;
    logic       crc_ok;
    logic       end_err;
    logic       timeout;

    always #5 clk = ~clk;

    sd_data_rx #(.TIMEOUT_CYCLES(100)) dut (
        .clk        (clk),
        .rst        (rst),
        .bit_en     (bit_en),
        .dat_in     (dat_in),
        .start      (start),
        .blk_len    (blk_len),
        .busy       (busy),
        .byte_out   (byte_out),
        .byte_valid (byte_valid),
        .done       (done),
        .crc_ok     (crc_ok),
        .end_err    (end_err),
        .timeout    (timeout)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] blk [0:511];
    logic [7:0] got_q [$];
    int         done_cnt = 0;
    int         to_cnt = 0;
    logic       last_ok = 1'b0;
    logic       last_err = 1'b0;
    logic       mid_start = 1'b0;

    typedef struct {
        logic [9:0]  len;
        int          n;
        logic [31:0] d;        // byte i at d[8*i +: 8]
        logic [15:0] crc_xor;  // nonzero corrupts the transmitted CRC
        logic        eb;
        logic        exp_ok;
        logic        exp_err;
    } vec_t;

    vec_t vt [4];

    // Sample outputs mid-cycle.
    always @(negedge clk) begin
        if (byte_valid) got_q.push_back(byte_out);
        if (done) begin
            done_cnt++;
            last_ok  = crc_ok;
            last_err = end_err;
        end
        if (timeout) to_cnt++;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic b, input int gap);
        bit_en = 1'b1;
        dat_in = b;
        tick();
        bit_en = 1'b0;
        dat_in = 1'b1;
        repeat (gap) tick();
    endtask

    task automatic arm(input logic [9:0] len);
        start   = 1'b1;
        blk_len = len;
        tick();
        start   = 1'b0;
    endtask

    function automatic logic [15:0] crc16_n(input int n);
        logic [15:0] c = 16'h0000;
        logic        fb;
        for (int i = 0; i < n; i++) begin
            for (int k = 7; k >= 0; k--) begin
                fb = c[15] ^ blk[i][k];
                c  = {c[14:0], 1'b0};
                if (fb) c = c ^ 16'h1021;
            end
        end
        return c;
    endfunction

    task automatic send_block(input int n, input logic [15:0] cv, input logic eb,
                              input int flip_byte, input int gap);
        logic [7:0] b;
        strobe(1'b1, gap);
        strobe(1'b1, gap);
        strobe(1'b0, gap);
        for (int i = 0; i < n; i++) begin
            b = blk[i];
            if (i == flip_byte) b = b ^ 8'h08;
            for (int k = 7; k >= 0; k--) begin
                if (mid_start && i == 0 && k == 3) begin
                    start   = 1'b1;
                    blk_len = 10'd1;
                end
                strobe(b[k], gap);
                start = 1'b0;
            end
        end
        for (int k = 15; k >= 0; k--) strobe(cv[k], gap);
        strobe(eb, gap);
    endtask

    task automatic wait_done(input string name, input int prev);
        for (int i = 0; i < 20 && done_cnt == prev; i++) tick();
        repeat (3) tick();
        chk({name, "_done_pulses"}, done_cnt - prev, 1);
        chk({name, "_busy_after"}, int'(busy), 0);
    endtask

    task automatic check_bytes(input string name, input int n, input int flip_byte);
        int         bad = 0;
        logic [7:0] e;
        chk({name, "_byte_count"}, got_q.size(), n);
        for (int i = 0; i < n && i < got_q.size(); i++) begin
            e = blk[i];
            if (i == flip_byte) e = e ^ 8'h08;
            if (got_q[i] !== e) bad++;
        end
        chk({name, "_bad_bytes"}, bad, 0);
    endtask

    initial begin
        int prev;
        int t0;

        vt[0] = '{10'd4, 4, 32'h04030201, 16'h0000, 1'b0, 1'b1, 1'b1};
        vt[1] = '{10'd1, 1, 32'h000000A5, 16'h0000, 1'b1, 1'b1, 1'b0};
        vt[2] = '{10'd2, 2, 32'h0000FF00, 16'h0001, 1'b1, 1'b0, 1'b0};
        vt[3] = '{10'd3, 3, 32'h007E0180, 16'h0000, 1'b1, 1'b1, 1'b0};

        rst = 1'b1; bit_en = 1'b0; dat_in = 1'b1; start = 1'b0; blk_len = 10'd0;
        repeat (3) tick();
        chk("rst_busy", int'(busy), 0);
        chk("rst_byte_out", int'(byte_out), 0);
        chk("rst_byte_valid", int'(byte_valid), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_crc_ok", int'(crc_ok), 0);
        chk("rst_end_err", int'(end_err), 0);
        chk("rst_timeout", int'(timeout), 0);
        rst = 1'b0;
        tick();

        // Short blocks from the table.
        for (int v = 0; v < 4; v++) begin
            for (int i = 0; i < vt[v].n; i++) blk[i] = vt[v].d[8*i +: 8];
            got_q.delete();
            prev = done_cnt;
            arm(vt[v].len);
            chk($sformatf("vec%0d_busy_armed", v), int'(busy), 1);
            send_block(vt[v].n, crc16_n(vt[v].n) ^ vt[v].crc_xor, vt[v].eb, -1, 1);
            wait_done($sformatf("vec%0d", v), prev);
            check_bytes($sformatf("vec%0d", v), vt[v].n, -1);
            chk($sformatf("vec%0d_crc_ok", v), int'(last_ok), int'(vt[v].exp_ok));
            chk($sformatf("vec%0d_end_err", v), int'(last_err), int'(vt[v].exp_err));
        end

        // Start pulse during DATA must be ignored.
        blk[0] = 8'h3C; blk[1] = 8'hC3;
        got_q.delete();
        prev = done_cnt;
        arm(10'd2);
        mid_start = 1'b1;
        send_block(2, crc16_n(2), 1'b1, -1, 1);
        mid_start = 1'b0;
        wait_done("midstart", prev);
        check_bytes("midstart", 2, -1);
        chk("midstart_crc_ok", int'(last_ok), 1);

        // Full 512-byte block of 0xFF with the known CRC 0x7FA1.
        for (int i = 0; i < 512; i++) blk[i] = 8'hFF;
        got_q.delete();
        prev = done_cnt;
        arm(10'd512);
        send_block(512, 16'h7FA1, 1'b1, -1, 0);
        wait_done("ff512", prev);
        check_bytes("ff512", 512, -1);
        chk("ff512_crc_ok", int'(last_ok), 1);
        chk("ff512_end_err", int'(last_err), 0);

        // Same block via blk_len=0, one bit flipped in byte 100.
        got_q.delete();
        prev = done_cnt;
        arm(10'd0);
        send_block(512, 16'h7FA1, 1'b1, 100, 0);
        wait_done("flip", prev);
        check_bytes("flip", 512, 100);
        chk("flip_crc_ok", int'(last_ok), 0);

        // Oversize length clamps to 512.
        got_q.delete();
        prev = done_cnt;
        arm(10'd600);
        send_block(512, 16'h7FA1, 1'b1, -1, 0);
        wait_done("clamp", prev);
        check_bytes("clamp", 512, -1);
        chk("clamp_crc_ok", int'(last_ok), 1);

        // Start-bit timeout: strobe every 3rd cycle, line high.
        prev = done_cnt;
        t0   = to_cnt;
        arm(10'd4);
        for (int i = 0; i < 99; i++) strobe(1'b1, 2);
        chk("to_busy_at_99", int'(busy), 1);
        chk("to_pulses_at_99", to_cnt - t0, 0);
        strobe(1'b1, 2);
        repeat (2) tick();
`ifdef SD_DATA_RX_TIMEOUT_EN
        chk("to_pulses_at_100", to_cnt - t0, 1);
        chk("to_busy_after", int'(busy), 0);
`else
        chk("to_pulses_at_100", to_cnt - t0, 0);
        chk("to_busy_after", int'(busy), 1);
`endif
        chk("to_no_done", done_cnt - prev, 0);

        // Reset in the middle of a 512-byte block, then a 1-byte block.
        rst = 1'b1; tick(); rst = 1'b0; tick();
        got_q.delete();
        arm(10'd1023);
        strobe(1'b1, 0);
        strobe(1'b0, 0);
        for (int i = 0; i < 88; i++) strobe(1'b1, 0);
        tick();
        chk("mid_bytes_before_rst", got_q.size(), 11);
        rst = 1'b1;
        tick();
        tick();
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_byte_out", int'(byte_out), 0);
        chk("mid_rst_byte_valid", int'(byte_valid), 0);
        chk("mid_rst_done", int'(done), 0);
        rst = 1'b0;
        tick();
        blk[0] = 8'h5A;
        got_q.delete();
        prev = done_cnt;
        arm(10'd1);
        send_block(1, crc16_n(1), 1'b1, -1, 1);
        wait_done("after_rst", prev);
        check_bytes("after_rst", 1, -1);
        chk("after_rst_crc_ok", int'(last_ok), 1);
        chk("after_rst_end_err", int'(last_err), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/sd_data_rx.md
SD_DATA_RX -- requirements
Module: sd_data_rx

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 65535, max bit_en cycles allowed in WAIT_START before timeout.
REQ-002 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-003 SHALL have port rst, input, 1, reset, synchronous and active-high.
REQ-004 SHALL have port bit_en, input, 1, SD bit strobe; dat_in is sampled only on cycles with bit_en=1.
REQ-005 SHALL have port dat_in, input, 1, serial DAT0 line.
REQ-006 SHALL have port start, input, 1, one-cycle arm pulse.
REQ-007 SHALL have port blk_len, input, 10, block length in bytes, captured on accepted start.
REQ-008 SHALL have port busy, output, 1, high in any state other than IDLE.
REQ-009 SHALL have port byte_out, output, 8, received data byte.
REQ-010 SHALL have port byte_valid, output, 1, one-cycle qualifier for byte_out.
REQ-011 SHALL have port done, output, 1, one-cycle block-complete pulse.
REQ-012 SHALL have port crc_ok, output, 1, CRC match result, valid with done and held until next accepted start.
REQ-013 SHALL have port end_err, output, 1, end bit not 1, valid with done.
REQ-014 SHALL have port timeout, output, 1, one-cycle pulse on start-bit timeout.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT_START, DATA, CRC, END_BIT.
- IDLE -> WAIT_START on start; start is ignored in any other state.
REQ-016 SHALL in WAIT_START, on bit_en with dat_in=0 (start bit), enter DATA with the bit and byte counters cleared.
REQ-017 SHALL in DATA shift bits MSB-first and raise byte_valid with the assembled byte on the cycle after its 8th bit is sampled.
- After blk_len*8 bits, go to CRC.
REQ-018 SHALL treat blk_len=0 as 512 bytes and clamp values >512 to 512.
REQ-019 SHALL feed every data bit, and no start, CRC, or end bit, into a CRC-16 of polynomial x^16+x^12+x^5+1, init 0x0000.
REQ-020 SHALL in CRC shift 16 received bits MSB-first into a compare register, then go to END_BIT.
REQ-021 SHALL in END_BIT, on the next bit_en, return to IDLE and, on the following cycle, pulse done.
- With done: crc_ok = (computed == received) and end_err = (dat_in==0).
REQ-022 SHALL make no state change on cycles with bit_en=0; the cycle after a qualifying bit_en, outputs react as specified in REQ-017 and REQ-021.
REQ-023 SHALL let done and byte_valid for the last byte coincide with neither pulse lost; done follows the last byte_valid by at least 17 bit_en strobes.

Reset
REQ-024 SHALL on rst, including mid-block, force IDLE and set outputs busy=0, byte_out=0x00, byte_valid=0, done=0, crc_ok=0, end_err=0, timeout=0, and CRC/counters to 0.
- rst has priority over start and bit_en.

Configuration
REQ-025 SHALL with SD_DATA_RX_TIMEOUT_EN defined count bit_en strobes in WAIT_START; on reaching TIMEOUT_CYCLES pulse timeout for one cycle and return to IDLE without done.
REQ-026 SHALL without SD_DATA_RX_TIMEOUT_EN wait in WAIT_START indefinitely, tie timeout to 0, and omit the counter.

Structure
REQ-027 SHALL place the state enum, the CRC polynomial constant 16'h1021, and the max block length 512 in shared package sd_pkg.
REQ-028 SHALL instantiate one sub-module sd_crc16_core: serial CRC-16 with clk, rst, clr, en, d in and crc[15:0] out.

Verification
REQ-029 SHALL cover: blk_len=512, all bytes 0xFF, CRC bits 0x7FA1, end=1 -> 512 byte_valid of 0xFF, done, crc_ok=1, end_err=0.
REQ-030 SHALL cover: same block with one data bit flipped in byte 100 -> done, crc_ok=0.
REQ-031 SHALL cover: blk_len=4, bytes 0x01 0x02 0x03 0x04, correct CRC, end bit=0 -> bytes in order, crc_ok=1, end_err=1.
REQ-032 SHALL cover: bit_en asserted every 3rd cycle with line held high; TIMEOUT_CYCLES=100 with macro -> timeout pulse after the 100th strobe, busy=0, no done.
REQ-033 SHALL cover: rst asserted after byte 10 of a 512-byte block, then a new start with blk_len=1 -> clean reception, crc_ok=1.
REQ-034 SHALL cover: start pulsed during DATA -> ignored, the in-flight block completes normally.
